ufm_burst_shadow_copy: RTL and testbench
========================================

UFM_BURST_SHADOW_COPY -- requirements
Module: ufm_burst_shadow_copy

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 512, number of words copied per run (>=1).
REQ-002 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum UFM burst length in words (power of 2, 1..NUM_WORDS).
REQ-004 SHALL have parameter SRC_BASE, default 0, first UFM word address.
REQ-005 SHALL have parameter DST_BASE, default 0, first RAM word address.
REQ-006 SHALL have parameter AUTO_START, default 1, 1 = start a copy on reset release.
REQ-007 SHALL derive localparams AW = $clog2(NUM_WORDS)+1 and BW = $clog2(BURST_LEN)+1.
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 start_i  input  1  single-cycle pulse; starts a copy when idle or complete.
REQ-011 ufm_addr_o  output  AW  UFM burst start word address.
REQ-012 ufm_read_o  output  1  UFM read request.
REQ-013 ufm_burst_count_o  output  BW  beats in the current burst.
REQ-014 ufm_wait_req_i  input  1  UFM stall; request held while high.
REQ-015 ufm_data_i  input  DATA_W  UFM read data.
REQ-016 ufm_valid_i  input  1  qualifies ufm_data_i, one beat per cycle.
REQ-017 ram_addr_o  output  AW  RAM word address.
REQ-018 ram_data_o  output  DATA_W  RAM write data.
REQ-019 ram_byte_enable_o  output  DATA_W/8  all ones during a write, zero otherwise.
REQ-020 ram_write_enable_o  output  1  RAM write strobe, one word per cycle.
REQ-021 busy_o  output  1  copy in progress.
REQ-022 complete_o  output  1  high from the end of a copy until the next start.
REQ-023 checksum_o  output  DATA_W  modulo-2^DATA_W sum of all copied words.

Function
REQ-024 SHALL use states IDLE, REQ, RECV, DONE; busy_o = (REQ or RECV); complete_o = DONE.
REQ-025 IDLE/DONE + start_i: SHALL clear the word counter and checksum, then go to REQ on the next cycle.
REQ-026 REQ: SHALL assert ufm_read_o with ufm_addr_o = SRC_BASE+count and ufm_burst_count_o = min(BURST_LEN, NUM_WORDS-count), all held stable while ufm_wait_req_i = 1.
REQ-027 REQ: on the first cycle with ufm_read_o=1 and ufm_wait_req_i=0, SHALL deassert read on the next cycle and go to RECV.
REQ-028 RECV: each ufm_valid_i beat SHALL produce exactly one RAM write one cycle later, with ram_data_o = beat data and ram_addr_o = DST_BASE+count; count then increments by 1.
REQ-029 ufm_valid_i asserted during the REQ acceptance cycle SHALL also be captured; no beat may be dropped.
REQ-030 After the last beat of a burst, SHALL go to REQ if count < NUM_WORDS, else to DONE; complete_o rises in the same cycle as the final RAM write.
REQ-031 Final burst SHALL be truncated when NUM_WORDS is not a multiple of BURST_LEN (e.g. 10 words, BURST_LEN 4 -> 4,4,2).
REQ-032 start_i SHALL be ignored while busy_o = 1.
REQ-033 ufm_valid_i outside RECV/REQ SHALL be ignored, and no RAM write SHALL result.
REQ-034 Address arithmetic SHALL wrap modulo 2^AW; no overflow flag.

Reset
REQ-035 reset SHALL force IDLE; ufm_read_o, ram_write_enable_o, busy_o, complete_o = 0; all addresses, ufm_burst_count_o, ram_data_o, ram_byte_enable_o and checksum_o = 0.
REQ-036 reset mid-copy SHALL abort on the next edge with no further RAM write.
REQ-037 With AUTO_START = 1, SHALL behave as though start_i pulsed on the first cycle after reset deasserts.

Configuration
REQ-038 Macro UFM_SHADOW_CHECKSUM_EN defined: checksum_o SHALL accumulate each written word in the cycle of its RAM write, and hold its value in DONE.
REQ-039 Macro not defined: checksum_o SHALL be constant 0, and no accumulator SHALL be synthesized.

Verification
REQ-040 NUM_WORDS=8, BURST_LEN=4, no wait, data=addr+0x100: required two bursts (addr 0, 4; count 4), RAM words 0..7 = 0x100..0x107, complete_o=1.
REQ-041 ufm_wait_req_i high for 3 cycles in REQ: ufm_addr_o, ufm_burst_count_o and ufm_read_o held for 3 cycles, then exactly one request accepted.
REQ-042 NUM_WORDS=10, BURST_LEN=4: burst counts 4,4,2; exactly 10 RAM writes.
REQ-043 reset asserted after the 3rd RAM write: no 4th write; outputs at reset values; with AUTO_START=1, copy restarts from word 0.
REQ-044 With UFM_SHADOW_CHECKSUM_EN, data 1..8: checksum_o=36 at DONE; start_i in DONE reruns the copy and checksum_o=36 again.
REQ-045 start_i pulsed while busy: ignored; total RAM writes still equal NUM_WORDS.

Source files
------------

// File: rtl/ufm_burst_shadow_copy.sv
// Copies NUM_WORDS words from UFM to RAM in bursts of up to BURST_LEN beats.
// Optional running checksum of copied words: define UFM_SHADOW_CHECKSUM_EN.
module ufm_burst_shadow_copy #(
    parameter int NUM_WORDS  = 512,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 4,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 0,
    parameter int AUTO_START = 1,
    localparam int AW = $clog2(NUM_WORDS) + 1,
    localparam int BW = $clog2(BURST_LEN) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    output logic [AW-1:0]       ufm_addr_o,
    output logic                ufm_read_o,
    output logic [BW-1:0]       ufm_burst_count_o,
    input  logic                ufm_wait_req_i,
    input  logic [DATA_W-1:0]   ufm_data_i,
    input  logic                ufm_valid_i,
    output logic [AW-1:0]       ram_addr_o,
    output logic [DATA_W-1:0]   ram_data_o,
    output logic [DATA_W/8-1:0] ram_byte_enable_o,
    output logic                ram_write_enable_o,
    output logic                busy_o,
    output logic                complete_o,
    output logic [DATA_W-1:0]   checksum_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RECV = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] count;
    logic [BW-1:0] beat_cnt;
    logic          auto_pend;

    logic          go;
    logic          accept;
    logic          beat;
    logic          last_beat;
    logic          end_burst;
    logic          more;
    logic [AW-1:0] count_nx;

    // Beats for a burst starting after done_words words; the tail burst is shortened.
    function automatic logic [BW-1:0] burst_for(input logic [AW-1:0] done_words);
        logic [AW-1:0] left;
        left = AW'(NUM_WORDS) - done_words;
        return (left > AW'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(left);
    endfunction

    always_comb begin
        go        = (start_i | auto_pend) & ((state == IDLE) | (state == DONE));
        accept    = (state == REQ) & ~ufm_wait_req_i;
        // A beat may arrive in the same cycle the request is accepted.
        beat      = ufm_valid_i & ((state == REQ) | (state == RECV));
        last_beat = beat & ((beat_cnt + BW'(1)) == ufm_burst_count_o);
        end_burst = last_beat & ((state == RECV) | accept);
        count_nx  = count + AW'(1);
        more      = count_nx < AW'(NUM_WORDS);
    end

    assign ufm_read_o = (state == REQ);
    assign busy_o     = (state == REQ) | (state == RECV);
    assign complete_o = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            count              <= '0;
            beat_cnt           <= '0;
            auto_pend          <= (AUTO_START != 0);
            ufm_addr_o         <= '0;
            ufm_burst_count_o  <= '0;
            ram_addr_o         <= '0;
            ram_data_o         <= '0;
            ram_byte_enable_o  <= '0;
            ram_write_enable_o <= 1'b0;
        end else begin
            auto_pend          <= 1'b0;
            ram_write_enable_o <= beat;
            ram_byte_enable_o  <= {(DATA_W/8){beat}};
            if (beat) begin
                ram_data_o <= ufm_data_i;
                ram_addr_o <= AW'(DST_BASE) + count;
                count      <= count_nx;
                beat_cnt   <= beat_cnt + BW'(1);
            end
            if (go) begin
                state             <= REQ;
                count             <= '0;
                beat_cnt          <= '0;
                ufm_addr_o        <= AW'(SRC_BASE);
                ufm_burst_count_o <= burst_for('0);
            end else if (end_burst) begin
                beat_cnt <= '0;
                if (more) begin
                    state             <= REQ;
                    ufm_addr_o        <= AW'(SRC_BASE) + count_nx;
                    ufm_burst_count_o <= burst_for(count_nx);
                end else begin
                    state <= DONE;
                end
            end else if (accept) begin
                state <= RECV;
            end
        end
    end

`ifdef UFM_SHADOW_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    // Updated on the edge that registers the RAM write, so it is current during that write.
    always_ff @(posedge clk) begin
        if (reset)     sum <= '0;
        else if (go)   sum <= '0;
        else if (beat) sum <= sum + ufm_data_i;
    end

    assign checksum_o = sum;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_ufm_burst_shadow_copy.sv
// Bench for ufm_burst_shadow_copy: UFM responder models feed a write scoreboard.
module tb_ufm_burst_shadow_copy;

    typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [3:0] a; logic [2:0] c; } br_a_t;
    typedef struct packed { logic [4:0] a; logic [2:0] c; } br_b_t;

`ifdef UFM_SHADOW_CHECKSUM_EN
    localparam logic [31:0] CSUM_A = 32'd36;
    localparam logic [31:0] CSUM_B = 32'd5165;
`else
    localparam logic [31:0] CSUM_A = 32'd0;
    localparam logic [31:0] CSUM_B = 32'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // DUT A: 8 words, bursts of 4
    logic        rst, start;
    logic [3:0]  a_addr, a_raddr;
    logic        a_read, a_wait, a_valid, a_we, a_busy, a_done;
    logic [2:0]  a_bcnt;
    logic [31:0] a_data, a_rdata, a_csum;
    logic [3:0]  a_be;

    ufm_burst_shadow_copy #(.NUM_WORDS(8), .DATA_W(32), .BURST_LEN(4),
                            .SRC_BASE(0), .DST_BASE(0), .AUTO_START(1)) u_a (
        .clk(clk), .reset(rst), .start_i(start),
        .ufm_addr_o(a_addr), .ufm_read_o(a_read), .ufm_burst_count_o(a_bcnt),
        .ufm_wait_req_i(a_wait), .ufm_data_i(a_data), .ufm_valid_i(a_valid),
        .ram_addr_o(a_raddr), .ram_data_o(a_rdata), .ram_byte_enable_o(a_be),
        .ram_write_enable_o(a_we), .busy_o(a_busy), .complete_o(a_done),
        .checksum_o(a_csum));

    // DUT B: 10 words, bursts of 4 -> tail of 2
    logic        b_rst, b_start, b_wait, b_valid, b_read, b_we, b_busy, b_done;
    logic [4:0]  b_addr, b_raddr;
    logic [2:0]  b_bcnt;
    logic [31:0] b_data, b_rdata, b_csum;
    logic [3:0]  b_be;

    assign b_start = 1'b0;
    assign b_wait  = 1'b0;

    ufm_burst_shadow_copy #(.NUM_WORDS(10), .DATA_W(32), .BURST_LEN(4),
                            .SRC_BASE(0), .DST_BASE(0), .AUTO_START(1)) u_b (
        .clk(clk), .reset(b_rst), .start_i(b_start),
        .ufm_addr_o(b_addr), .ufm_read_o(b_read), .ufm_burst_count_o(b_bcnt),
        .ufm_wait_req_i(b_wait), .ufm_data_i(b_data), .ufm_valid_i(b_valid),
        .ram_addr_o(b_raddr), .ram_data_o(b_rdata), .ram_byte_enable_o(b_be),
        .ram_write_enable_o(b_we), .busy_o(b_busy), .complete_o(b_done),
        .checksum_o(b_csum));

    // UFM model A: optional first beat in the accept cycle, random gaps, stray valids
    logic [31:0] a_doff;
    logic        a_early, a_gap_en, a_stray, a_gap;
    logic [3:0]  a_baddr;
    int          a_left;
    logic        a_hit, a_beat;
    logic [3:0]  a_beat_addr;
    wr_t         sb_a[$];
    br_a_t       blog_a[$];

    assign a_hit       = a_early && a_read && !a_wait;
    assign a_beat      = a_hit || (a_left > 0 && !a_gap);
    assign a_beat_addr = a_hit ? a_addr : a_baddr;
    assign a_valid     = a_beat || a_stray;
    assign a_data      = a_beat ? a_doff + {28'd0, a_beat_addr} : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst) begin
            a_left  <= 0;
            a_baddr <= '0;
            a_gap   <= 1'b0;
            sb_a.delete();
        end else begin
            a_gap <= a_gap_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (a_beat) sb_a.push_back(wr_t'{addr: a_beat_addr, data: a_data});
            if (a_read && !a_wait) begin
                blog_a.push_back(br_a_t'{a: a_addr, c: a_bcnt});
                a_baddr <= a_addr + (a_early ? 4'd1 : 4'd0);
                a_left  <= int'(a_bcnt) - (a_early ? 1 : 0);
            end else if (a_beat) begin
                a_baddr <= a_baddr + 4'd1;
                a_left  <= a_left - 1;
            end
        end
    end

    // UFM model B: plain back-to-back beats, data = 0x200 + address
    logic [4:0] b_baddr;
    int         b_left;
    br_b_t      blog_b[$];

    assign b_valid = b_left > 0;
    assign b_data  = 32'h200 + {27'd0, b_baddr};

    always @(posedge clk) begin
        if (b_rst) begin
            b_left  <= 0;
            b_baddr <= '0;
        end else if (b_read && !b_wait) begin
            blog_b.push_back(br_b_t'{a: b_addr, c: b_bcnt});
            b_baddr <= b_addr;
            b_left  <= int'(b_bcnt);
        end else if (b_left > 0) begin
            b_baddr <= b_baddr + 5'd1;
            b_left  <= b_left - 1;
        end
    end

    int          a_wr_count = 0;
    int          b_cnt = 0;
    logic [31:0] a_ram [16];

    // Advance one cycle and drain any RAM write into the scoreboards.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (a_we) begin
            a_wr_count++;
            tests_run++;
            if (sb_a.size() == 0) begin
                tests_failed++;
                $display("FAIL a_unexpected_write: addr=%0h data=%0h, no beat outstanding", a_raddr, a_rdata);
            end else begin
                e = sb_a.pop_front();
                if ({a_raddr, a_rdata, a_be} !== {e.addr, e.data, 4'hF}) begin
                    tests_failed++;
                    $display("FAIL a_ram_write: got addr=%0h data=%0h be=%0h, want addr=%0h data=%0h be=f",
                             a_raddr, a_rdata, a_be, e.addr, e.data);
                end
            end
            a_ram[a_raddr] = a_rdata;
        end
        if (b_we) begin
            tests_run++;
            if ({b_raddr, b_rdata, b_be} !== {5'(b_cnt), 32'h200 + 32'(b_cnt), 4'hF}) begin
                tests_failed++;
                $display("FAIL b_ram_write: got addr=%0h data=%0h be=%0h, want addr=%0h data=%0h be=f",
                         b_raddr, b_rdata, b_be, b_cnt, 32'h200 + 32'(b_cnt));
            end
            b_cnt++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done_a(output logic we_at_rise);
        int n;
        n = 0;
        do begin tick(); n++; end while (!a_done && n < 200);
        tests_run++;
        if (!a_done) begin
            tests_failed++;
            $display("FAIL a_done_timeout: complete_o=%0b after %0d cycles, want 1", a_done, n);
        end
        we_at_rise = a_we;
    endtask

    task automatic test_reset();
        tick();
        tests_run++;
        if ({a_read, a_we, a_busy, a_done, a_addr, a_bcnt, a_raddr, a_be} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: read=%0b we=%0b busy=%0b done=%0b addr=%0h bcnt=%0h raddr=%0h be=%0h, want all 0",
                     a_read, a_we, a_busy, a_done, a_addr, a_bcnt, a_raddr, a_be);
        end
        tests_run++;
        if ({a_rdata, a_csum} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_data: ram_data=%0h checksum=%0h, want 0", a_rdata, a_csum);
        end
    endtask

    // Auto-start after reset; two bursts of 4 with data = addr + 0x100.
    task automatic test_basic();
        int base, w0;
        logic we_rise;
        base = blog_a.size();
        w0 = a_wr_count;
        rst = 1'b0;
        wait_done_a(we_rise);
        tests_run++;
        if (we_rise !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_done_with_last_write: we at complete rise=%0b, want 1", we_rise);
        end
        tests_run++;
        if (blog_a.size() - base != 2 || blog_a[base] !== br_a_t'{a: 4'd0, c: 3'd4}
            || blog_a[base+1] !== br_a_t'{a: 4'd4, c: 3'd4}) begin
            tests_failed++;
            $display("FAIL basic_bursts: got %0d bursts, want 2 at addr 0,4 count 4", blog_a.size() - base);
        end
        tests_run++;
        if (a_wr_count - w0 != 8 || a_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_writes: writes=%0d busy=%0b, want 8 and 0", a_wr_count - w0, a_busy);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (a_ram[i] !== 32'h100 + 32'(i)) begin
                tests_failed++;
                $display("FAIL basic_ram[%0d]: got %0h, want %0h", i, a_ram[i], 32'h100 + 32'(i));
            end
        end
    endtask

    // Request must hold steady through a 3-cycle stall and be accepted once.
    task automatic test_wait();
        int base;
        logic we_rise;
        base = blog_a.size();
        a_wait = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({a_read, a_addr, a_bcnt} !== {1'b1, 4'd0, 3'd4} || blog_a.size() != base) begin
                tests_failed++;
                $display("FAIL wait_hold[%0d]: read=%0b addr=%0h bcnt=%0d accepted=%0d, want 1/0/4/0",
                         i, a_read, a_addr, a_bcnt, blog_a.size() - base);
            end
            if (i < 2) tick();
        end
        a_wait = 1'b0;
        wait_done_a(we_rise);
        tests_run++;
        if (blog_a.size() - base != 2 || blog_a[base] !== br_a_t'{a: 4'd0, c: 3'd4}) begin
            tests_failed++;
            $display("FAIL wait_accept: got %0d bursts, want 2 with first at addr 0", blog_a.size() - base);
        end
    endtask

    // First beat in the accept cycle, then a run with random beat gaps.
    task automatic test_early_and_gaps();
        int w0;
        logic we_rise;
        for (int m = 0; m < 2; m++) begin
            a_early  = (m == 0);
            a_gap_en = (m == 1);
            w0 = a_wr_count;
            pulse_start();
            wait_done_a(we_rise);
            tests_run++;
            if (a_wr_count - w0 != 8 || sb_a.size() != 0) begin
                tests_failed++;
                $display("FAIL early_gaps[%0d]: writes=%0d pending=%0d, want 8 and 0", m, a_wr_count - w0, sb_a.size());
            end
        end
        a_early  = 1'b0;
        a_gap_en = 1'b0;
    endtask

    task automatic test_stray_valid();
        int w0;
        w0 = a_wr_count;
        a_stray = 1'b1;
        repeat (4) tick();
        a_stray = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (a_wr_count != w0 || a_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL stray_valid: writes=%0d done=%0b, want 0 and 1", a_wr_count - w0, a_done);
        end
    endtask

    task automatic test_busy_start();
        int base, w0;
        logic we_rise;
        base = blog_a.size();
        w0 = a_wr_count;
        pulse_start();
        repeat (3) tick();
        tests_run++;
        if (a_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_busy: busy=%0b, want 1", a_busy);
        end
        pulse_start();
        tick();
        pulse_start();
        wait_done_a(we_rise);
        repeat (3) tick();
        tests_run++;
        if (a_wr_count - w0 != 8 || blog_a.size() - base != 2) begin
            tests_failed++;
            $display("FAIL busy_start: writes=%0d bursts=%0d, want 8 and 2", a_wr_count - w0, blog_a.size() - base);
        end
    endtask

    task automatic test_reset_mid_copy();
        int base, w0, n;
        logic we_rise;
        w0 = a_wr_count;
        n = 0;
        pulse_start();
        while (a_wr_count - w0 < 3 && n < 100) begin tick(); n++; end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({a_we, a_read, a_busy, a_done, a_addr, a_bcnt, a_raddr, a_be, a_rdata, a_csum} !== '0
            || a_wr_count - w0 != 3) begin
            tests_failed++;
            $display("FAIL reset_mid_copy: we=%0b busy=%0b addr=%0h raddr=%0h data=%0h writes=%0d, want 0s and 3 writes",
                     a_we, a_busy, a_addr, a_raddr, a_rdata, a_wr_count - w0);
        end
        tick();
        base = blog_a.size();
        w0 = a_wr_count;
        rst = 1'b0;
        wait_done_a(we_rise);
        tests_run++;
        if (blog_a.size() - base != 2 || blog_a[base] !== br_a_t'{a: 4'd0, c: 3'd4} || a_wr_count - w0 != 8) begin
            tests_failed++;
            $display("FAIL reset_restart: bursts=%0d writes=%0d, want 2 from addr 0 and 8", blog_a.size() - base, a_wr_count - w0);
        end
    endtask

    task automatic test_checksum();
        logic we_rise;
        a_doff = 32'd1;
        pulse_start();
        wait_done_a(we_rise);
        tests_run++;
        if (a_csum !== CSUM_A) begin
            tests_failed++;
            $display("FAIL checksum_first: got %0d, want %0d", a_csum, CSUM_A);
        end
        pulse_start();
        tests_run++;
        if (a_csum !== 32'd0 || a_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL checksum_cleared: checksum=%0d busy=%0b, want 0 and 1", a_csum, a_busy);
        end
        wait_done_a(we_rise);
        tests_run++;
        if (a_csum !== CSUM_A) begin
            tests_failed++;
            $display("FAIL checksum_rerun: got %0d, want %0d", a_csum, CSUM_A);
        end
        a_doff = 32'h100;
    endtask

    task automatic test_truncation();
        int n;
        n = 0;
        b_rst = 1'b0;
        do begin tick(); n++; end while (!b_done && n < 200);
        tests_run++;
        if (blog_b.size() != 3 || blog_b[0] !== br_b_t'{a: 5'd0, c: 3'd4}
            || blog_b[1] !== br_b_t'{a: 5'd4, c: 3'd4} || blog_b[2] !== br_b_t'{a: 5'd8, c: 3'd2}) begin
            tests_failed++;
            $display("FAIL trunc_bursts: got %0d bursts (last count %0d), want 4,4,2",
                     blog_b.size(), blog_b.size() > 0 ? blog_b[blog_b.size()-1].c : 3'd0);
        end
        repeat (3) tick();
        tests_run++;
        if (b_cnt != 10 || b_done !== 1'b1 || b_busy !== 1'b0 || b_csum !== CSUM_B) begin
            tests_failed++;
            $display("FAIL trunc_done: writes=%0d done=%0b busy=%0b checksum=%0d, want 10/1/0/%0d",
                     b_cnt, b_done, b_busy, b_csum, CSUM_B);
        end
    endtask

    initial begin
        rst      = 1'b1;
        b_rst    = 1'b1;
        start    = 1'b0;
        a_wait   = 1'b0;
        a_early  = 1'b0;
        a_gap_en = 1'b0;
        a_stray  = 1'b0;
        a_doff   = 32'h100;
        for (int i = 0; i < 16; i++) a_ram[i] = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_wait();
        test_early_and_gaps();
        test_stray_valid();
        test_busy_start();
        test_reset_mid_copy();
        test_checksum();
        test_truncation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
